// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU built-in self-test engine.
// Optional build macro ALU_BIST_ERR_INJECT_EN is handled in alu_bist.sv.
package alu_bist_pkg;

  localparam int NUM_VEC_DEF = 13;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_NOR = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;
  localparam logic [3:0] OP_ROL = 4'b1010;
  localparam logic [3:0] OP_ROR = 4'b1011;
  localparam logic [3:0] OP_EQ  = 4'b1100;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  typedef struct packed {
    logic [3:0] ctrl;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] exp_out;
    logic       exp_carry;
    logic       chk_carry;
  } vec_t;

  // Carry is only meaningful for the arithmetic opcodes.
  function automatic vec_t mk_vec(input logic [3:0] c, input logic [7:0] x,
                                  input logic [7:0] y, input logic [7:0] e,
                                  input logic ec);
    vec_t v;
    v.ctrl      = c;
    v.x         = x;
    v.y         = y;
    v.exp_out   = e;
    v.exp_carry = ec;
    v.chk_carry = (c == OP_ADD) || (c == OP_SUB);
    return v;
  endfunction

endpackage

// File: rtl/alu_bist_rom.sv
// Golden vector table: one vector per opcode, in opcode order.
// Shift/rotate amounts come from y[2:0]; SUB carry means "no borrow".
module alu_bist_rom
  import alu_bist_pkg::*;
#(
  parameter int NUM_VEC = NUM_VEC_DEF
) (
  input  logic [3:0] idx_i,
  output vec_t       vec_o
);

  always_comb begin
    vec_o = '0;
    case (idx_i)
      4'd0:  vec_o = mk_vec(OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1);
      4'd1:  vec_o = mk_vec(OP_SUB, 8'hFF, 8'hFF, 8'h00, 1'b1);
      4'd2:  vec_o = mk_vec(OP_AND, 8'h05, 8'h03, 8'h01, 1'b0);
      4'd3:  vec_o = mk_vec(OP_OR,  8'h05, 8'h03, 8'h07, 1'b0);
      4'd4:  vec_o = mk_vec(OP_NOT, 8'h5A, 8'h00, 8'hA5, 1'b0);
      4'd5:  vec_o = mk_vec(OP_XOR, 8'h0F, 8'hFF, 8'hF0, 1'b0);
      4'd6:  vec_o = mk_vec(OP_NOR, 8'h0F, 8'h30, 8'hC0, 1'b0);
      4'd7:  vec_o = mk_vec(OP_SLL, 8'h81, 8'h01, 8'h02, 1'b0);
      4'd8:  vec_o = mk_vec(OP_SRL, 8'h81, 8'h01, 8'h40, 1'b0);
      4'd9:  vec_o = mk_vec(OP_SRA, 8'h81, 8'h01, 8'hC0, 1'b0);
      4'd10: vec_o = mk_vec(OP_ROL, 8'h81, 8'h01, 8'h03, 1'b0);
      4'd11: vec_o = mk_vec(OP_ROR, 8'h81, 8'h01, 8'hC0, 1'b0);
      4'd12: vec_o = mk_vec(OP_EQ,  8'hFF, 8'hFF, 8'h01, 1'b0);
      default: vec_o = '0;
    endcase
    if (int'(idx_i) >= NUM_VEC) vec_o = '0;
  end

endmodule

// File: rtl/alu_bist.sv
// BIST engine: drives ROM vectors into the ALU, samples after a settle time, counts mismatches.
// Define ALU_BIST_ERR_INJECT_EN to add inj_en/inj_idx for forcing a mismatch on one vector.
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int NUM_VEC    = NUM_VEC_DEF,
  parameter int SETTLE_CYC = 1,
  parameter int ERR_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [3:0]       alu_ctrl,
  output logic [7:0]       alu_x,
  output logic [7:0]       alu_y,
  input  logic             alu_carry,
  input  logic [7:0]       alu_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [3:0]       fail_idx
`ifdef ALU_BIST_ERR_INJECT_EN
  ,
  input  logic             inj_en,
  input  logic [3:0]       inj_idx
`endif
);

  localparam int         CNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [3:0] LAST  = 4'(NUM_VEC - 1);

  logic [2:0]       state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [7:0]       x_q, x_d, y_q, y_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d, err_nxt;
  logic             fv_q, fv_d;
  logic [3:0]       fidx_q, fidx_d;

  vec_t       vec;
  logic [7:0] exp_out;
  logic       mism;

  alu_bist_rom #(.NUM_VEC(NUM_VEC)) u_rom (
    .idx_i (idx_q),
    .vec_o (vec)
  );

`ifdef ALU_BIST_ERR_INJECT_EN
  assign exp_out = vec.exp_out ^ ((inj_en && (idx_q == inj_idx)) ? 8'h01 : 8'h00);
`else
  assign exp_out = vec.exp_out;
`endif

  assign mism    = (alu_out != exp_out) || (vec.chk_carry && (alu_carry != vec.exp_carry));
  assign err_nxt = (!mism || (&err_q)) ? err_q : err_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    x_d     = x_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fidx_d  = fidx_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DRIVE;
          idx_d   = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          fidx_d  = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_DRIVE: begin
        ctrl_d  = vec.ctrl;
        x_d     = vec.x;
        y_d     = vec.y;
        cnt_d   = CNT_W'(SETTLE_CYC);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        err_d = err_nxt;
        if (mism && !fv_q) begin
          fv_d   = 1'b1;
          fidx_d = idx_q;
        end
        if (idx_q == LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_nxt == '0);
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      x_q     <= x_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fidx_q  <= fidx_d;
    end
  end

  assign alu_ctrl   = ctrl_q;
  assign alu_x      = x_q;
  assign alu_y      = y_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_idx   = fidx_q;

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: behavioural ALU (with selectable faults) plus a run-timeline model.
// Inject tests are compiled in when ALU_BIST_ERR_INJECT_EN is defined.
module tb_alu_bist;
  localparam int N   = 13;
  localparam int S   = 1;
  localparam int P   = S + 2;
  localparam int TD  = 1 + N * P;   // 40 edges from the start edge to done
  localparam int TD3 = 1 + N * 5;   // 66 for the SETTLE_CYC=3 instance

  logic       clk = 0, rst = 0, start = 0, start3 = 0;
  logic [3:0] alu_ctrl, ctrl3, err_count, fail_idx, err3, fidx3;
  logic [7:0] alu_x, alu_y, alu_out, x3, y3, out3;
  logic       alu_carry, carry3, busy, done, pass, fail_valid, busy3, done3, pass3, fv3;
  logic       inj_en = 0;
  logic [3:0] inj_idx = 0;
  int mode = 0, t = -1, checks = 0, errors = 0;

  // Reference vector table written straight from the opcode definitions.
  logic [3:0] T_CTRL [N] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
  logic [7:0] T_X    [N] = '{8'hFF, 8'hFF, 8'h05, 8'h05, 8'h5A, 8'h0F, 8'h0F, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'hFF};
  logic [7:0] T_Y    [N] = '{8'h01, 8'hFF, 8'h03, 8'h03, 8'h00, 8'hFF, 8'h30, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'hFF};
  logic [7:0] T_OUT  [N] = '{8'h00, 8'h00, 8'h01, 8'h07, 8'hA5, 8'hF0, 8'hC0, 8'h02, 8'h40, 8'hC0, 8'h03, 8'hC0, 8'h01};
  logic       T_C    [N] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  // mode: 0 golden, 1 AND returns OR, 2 carry inverted on ADD, 3 carry inverted on AND, 4 all outputs inverted
  function automatic logic [8:0] alu_fn(input int m, input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
    logic [7:0]  o;
    logic        co;
    logic [15:0] xx;
    int          s;
    s  = int'(y[2:0]);
    xx = {x, x};
    co = 1'b0;
    o  = 8'h00;
    case (c)
      4'd0:  {co, o} = {1'b0, x} + {1'b0, y};
      4'd1:  begin o = x - y; co = (x >= y); end
      4'd2:  o = x & y;
      4'd3:  o = x | y;
      4'd4:  o = ~x;
      4'd5:  o = x ^ y;
      4'd6:  o = ~(x | y);
      4'd7:  o = x << s;
      4'd8:  o = x >> s;
      4'd9:  o = 8'($signed(x) >>> s);
      4'd10: begin xx = xx << s; o = xx[15:8]; end
      4'd11: begin xx = xx >> s; o = xx[7:0]; end
      4'd12: o = {7'd0, x == y};
      default: o = 8'h00;
    endcase
    if (m == 1 && c == 4'd2) o = x | y;
    if (m == 2 && c == 4'd0) co = ~co;
    if (m == 3 && c == 4'd2) co = ~co;
    if (m == 4) o = ~o;
    return {co, o};
  endfunction

  always_comb {alu_carry, alu_out} = alu_fn(mode, alu_ctrl, alu_x, alu_y);
  always_comb {carry3, out3} = alu_fn(0, ctrl3, x3, y3);

  alu_bist #(.NUM_VEC(N), .SETTLE_CYC(S), .ERR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
    .alu_carry(alu_carry), .alu_out(alu_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .fail_idx(fail_idx)
`ifdef ALU_BIST_ERR_INJECT_EN
    , .inj_en(inj_en), .inj_idx(inj_idx)
`endif
  );

  alu_bist #(.NUM_VEC(N), .SETTLE_CYC(3), .ERR_W(4)) dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .alu_ctrl(ctrl3), .alu_x(x3), .alu_y(y3),
    .alu_carry(carry3), .alu_out(out3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .fail_valid(fv3), .fail_idx(fidx3)
`ifdef ALU_BIST_ERR_INJECT_EN
    , .inj_en(1'b0), .inj_idx(4'd0)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0d got %0d want %0d", nm, t, act, exp);
    end
  endtask

  function automatic bit mism(input int k);
    logic [8:0] r;
    logic [7:0] e;
    r = alu_fn(mode, T_CTRL[k], T_X[k], T_Y[k]);
    e = T_OUT[k];
    if (inj_en && int'(inj_idx) == k) e = e ^ 8'h01;
    return (r[7:0] != e) || ((T_CTRL[k] <= 4'd1) && (r[8] != T_C[k]));
  endfunction

  // Timeline model: vector k is driven at edge 2+k*P and sampled at edge 1+(k+1)*P.
  always @(negedge clk) begin : cmp
    int ns, nd, e, fi;
    bit fv;
    if (t >= 1 && !rst) begin
      ns = (t >= TD) ? N : (t - 1) / P;
      nd = (t >= TD) ? N : ((t >= 2) ? (t - 2) / P + 1 : 0);
      e = 0; fi = 0; fv = 0;
      for (int k = 0; k < ns; k++)
        if (mism(k)) begin
          if (!fv) fi = k;
          fv = 1;
          e++;
        end
      if (e > 15) e = 15;
      chk("busy", busy, int'(t < TD));
      chk("done", done, int'(t >= TD));
      chk("pass", pass, int'(t >= TD && !fv));
      chk("err_count", err_count, e);
      chk("fail_valid", fail_valid, fv);
      chk("fail_idx", fail_idx, fi);
      if (nd > 0) begin
        chk("alu_ctrl", alu_ctrl, T_CTRL[nd-1]);
        chk("alu_x", alu_x, T_X[nd-1]);
        chk("alu_y", alu_y, T_Y[nd-1]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    if (t >= 0) t++;
  endtask

  // Call at #1 after an edge; the following edge samples start.
  task automatic pulse_start();
    start = 1;
    t = 0;
    step();
    #1 start = 0;
  endtask

  task automatic run_to_done();
    while (t < TD) step();
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_fv"}, fail_valid, 0);
    chk({tag, "_fidx"}, fail_idx, 0);
    chk({tag, "_ctrl"}, alu_ctrl, 0);
    chk({tag, "_x"}, alu_x, 0);
    chk({tag, "_y"}, alu_y, 0);
  endtask

  initial begin
    #1 rst = 1;
    #1 check_all_zero("reset");
    step(); step();
    #1 rst = 0;
    step();
    #1;

    // golden ALU
    mode = 0;
    pulse_start();
    chk("t1_busy_next_edge", busy, 1);
    run_to_done();
    chk("t1_done", done, 1);
    chk("t1_pass", pass, 1);
    chk("t1_err", err_count, 0);
    chk("t1_fv", fail_valid, 0);

    // AND returns OR; restart from DONE
    mode = 1;
    pulse_start();
    run_to_done();
    chk("t2_err", err_count, 1);
    chk("t2_fidx", fail_idx, 2);
    chk("t2_fv", fail_valid, 1);
    chk("t2_pass", pass, 0);

    mode = 2;
    pulse_start();
    run_to_done();
    chk("t3_add_carry_err", err_count, 1);
    chk("t3_add_carry_fidx", fail_idx, 0);

    mode = 3;
    pulse_start();
    run_to_done();
    chk("t3_and_carry_pass", pass, 1);

    mode = 4;
    pulse_start();
    run_to_done();
    chk("all_bad_err", err_count, 13);
    chk("all_bad_fidx", fail_idx, 0);

    // restart from DONE clears counters; start while busy is ignored
    mode = 0;
    pulse_start();
    chk("t5_err_cleared", err_count, 0);
    chk("t5_done_cleared", done, 0);
    repeat (9) step();
    #1 start = 1;
    step();
    #1 start = 0;
    run_to_done();
    chk("t5_done_at_40", t, TD);
    chk("t5_pass", pass, 1);

    // reset while idx=5
    mode = 1;
    pulse_start();
    while (t < 2 + 5 * P) step();
    #1 rst = 1;
    t = -1;
    #1 check_all_zero("t4_midrun");
    step();
    #1 rst = 0;
    mode = 0;
    pulse_start();
    run_to_done();
    chk("t4_clean_pass", pass, 1);
    chk("t4_clean_err", err_count, 0);

`ifdef ALU_BIST_ERR_INJECT_EN
    inj_en = 1;
    inj_idx = 4'd12;
    pulse_start();
    run_to_done();
    chk("t6_inj_err", err_count, 1);
    chk("t6_inj_fidx", fail_idx, 12);
    chk("t6_inj_pass", pass, 0);
    inj_en = 0;
`endif

    // SETTLE_CYC=3 instance: done after 66 edges
    start3 = 1;
    step();
    #1 start3 = 0;
    chk("s3_busy", busy3, 1);
    repeat (TD3 - 2) step();
    #1 chk("s3_not_done_65", done3, 0);
    step();
    #1 chk("s3_done_66", done3, 1);
    chk("s3_pass", pass3, 1);
    chk("s3_err", err3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout t=%0d", t);
    $fatal(1);
  end

endmodule
